// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter handshake bundle; master = arbiter (drives req_ready, tx_data, tx_en, grant_id, busy, err_timeout), slave = environment (drives req_valid, req_data, tx_busy)
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0] req_ready;
  logic [7:0] tx_data;
  logic tx_en;
  logic tx_busy;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic busy;
  logic err_timeout;
  modport master (
    input req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_en, grant_id, busy, err_timeout
  );
  modport slave (
    output req_valid, req_data, tx_busy,
    input req_ready, tx_data, tx_en, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; ports clk, rst_n (sync active-low), bus (requester valid/data/ready, tx_data/tx_en/tx_busy, grant_id, busy, err_timeout)
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int START_TIMEOUT = 20000
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;
  state_t state, state_n;
  logic [GW-1:0] ptr, ptr_n, off, g, grant_n;
  logic [GW:0] sum;
  logic [N_REQ-1:0] rot, ready_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] dsel, data_n;
  logic en_n, err_n;
  always_comb begin
    rot = N_REQ'({bus.req_valid, bus.req_valid} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = GW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    g = sum >= (GW+1)'(N_REQ) ? GW'(sum - (GW+1)'(N_REQ)) : GW'(sum);
    dsel = '0;
    for (int i = 0; i < N_REQ; i++) if (g == GW'(i)) dsel = bus.req_data[8*i +: 8];
    state_n = state;
    ptr_n = ptr;
    grant_n = bus.grant_id;
    data_n = bus.tx_data;
    en_n = bus.tx_en;
    cnt_n = cnt;
    ready_n = '0;
    err_n = 1'b0;
    unique case (state)
      IDLE: if (|bus.req_valid) begin
        state_n = START;
        ptr_n = g == GW'(N_REQ - 1) ? '0 : g + GW'(1);
        grant_n = g;
        data_n = dsel;
        en_n = 1'b1;
        ready_n = N_REQ'(1) << g;
        cnt_n = '0;
      end
      START: begin
        cnt_n = cnt + CW'(1);
        if (bus.tx_busy) begin
          en_n = 1'b0;
          state_n = WAIT_DONE;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          en_n = 1'b0;
          err_n = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_DONE: state_n = bus.tx_busy ? WAIT_DONE : GAP;
      GAP: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.tx_data <= '0;
      bus.tx_en <= 1'b0;
      bus.req_ready <= '0;
      bus.grant_id <= '0;
      bus.busy <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      bus.tx_data <= data_n;
      bus.tx_en <= en_n;
      bus.req_ready <= ready_n;
      bus.grant_id <= grant_n;
      bus.busy <= state_n != IDLE;
      bus.err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors for uart_tx_arbiter with hand-computed expectations
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  uart_tx_arbiter_if #(.N_REQ(4)) bus ();
  uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_en(input string tag);
    int k = 0;
    while (bus.tx_en !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, " tx_en"}, 32'(bus.tx_en), 1);
  endtask
  task automatic xmit(input string tag);
    bus.tx_busy = 1'b1;
    tick();
    check({tag, " ready pulse"}, 32'(bus.req_ready), 0);
    check({tag, " en drop"}, 32'(bus.tx_en), 0);
    repeat (3) tick();
    bus.tx_busy = 1'b0;
    tick();
    tick();
    check({tag, " idle"}, 32'(bus.busy), 0);
  endtask
  task automatic frame(input string tag, input logic [1:0] eg, input logic [7:0] ed);
    logic [3:0] m;
    m = 4'b0001 << eg;
    wait_en(tag);
    check({tag, " grant"}, 32'(bus.grant_id), 32'(eg));
    check({tag, " data"}, 32'(bus.tx_data), 32'(ed));
    check({tag, " ready"}, 32'(bus.req_ready), 32'(m));
    xmit(tag);
  endtask
  initial begin
    int cyc, errs;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data = 32'h13121110;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst tx_en", 32'(bus.tx_en), 0);
      check("rst ready", 32'(bus.req_ready), 0);
      check("rst busy", 32'(bus.busy), 0);
    end
    check("rst data", 32'(bus.tx_data), 0);
    check("rst grant", 32'(bus.grant_id), 0);
    check("rst err", 32'(bus.err_timeout), 0);
    rst_n = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    check("idle busy", 32'(bus.busy), 0);
    bus.req_valid = 4'b0100;
    bus.req_data = 32'h00410000;
    tick();
    check("single tx_en", 32'(bus.tx_en), 1);
    check("single data", 32'(bus.tx_data), 32'h41);
    check("single grant", 32'(bus.grant_id), 2);
    check("single ready", 32'(bus.req_ready), 32'b0100);
    check("single busy", 32'(bus.busy), 1);
    bus.req_valid = 4'b0000;
    tick();
    check("single ready off", 32'(bus.req_ready), 0);
    repeat (3) tick();
    check("single en held", 32'(bus.tx_en), 1);
    bus.tx_busy = 1'b1;
    tick();
    check("single en fall", 32'(bus.tx_en), 0);
    repeat (99) tick();
    check("single busy mid", 32'(bus.busy), 1);
    check("single en low", 32'(bus.tx_en), 0);
    bus.tx_busy = 1'b0;
    tick();
    check("single gap busy", 32'(bus.busy), 1);
    tick();
    check("single busy fall", 32'(bus.busy), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data = 32'h13121110;
    frame("rr0", 2'd0, 8'h10);
    frame("rr1", 2'd1, 8'h11);
    frame("rr2", 2'd2, 8'h12);
    frame("rr3", 2'd3, 8'h13);
    frame("rr4", 2'd0, 8'h10);
    bus.req_valid = 4'b1000;
    frame("wrap3", 2'd3, 8'h13);
    bus.req_valid = 4'b0010;
    frame("skip1", 2'd1, 8'h11);
    bus.req_valid = 4'b0011;
    frame("pair0", 2'd0, 8'h10);
    frame("pair1", 2'd1, 8'h11);
    bus.req_valid = 4'b0110;
    wait_en("tmo");
    check("tmo grant", 32'(bus.grant_id), 2);
    bus.req_valid = 4'b0010;
    cyc = 0;
    errs = 0;
    do begin
      cyc++;
      tick();
      errs += int'(bus.err_timeout);
    end while (bus.tx_en === 1'b1 && cyc < 30);
    check("tmo en cycles", 32'(cyc), 8);
    check("tmo err pulses", 32'(errs), 1);
    check("tmo idle", 32'(bus.busy), 0);
    tick();
    check("tmo err clear", 32'(bus.err_timeout), 0);
    check("tmo next en", 32'(bus.tx_en), 1);
    check("tmo next grant", 32'(bus.grant_id), 1);
    xmit("tmo next");
    bus.req_valid = 4'b0011;
    wait_en("mid");
    check("mid grant", 32'(bus.grant_id), 0);
    bus.tx_busy = 1'b1;
    tick();
    check("mid wait", 32'(bus.tx_en), 0);
    rst_n = 1'b0;
    tick();
    check("mid rst en", 32'(bus.tx_en), 0);
    check("mid rst busy", 32'(bus.busy), 0);
    check("mid rst err", 32'(bus.err_timeout), 0);
    rst_n = 1'b1;
    bus.tx_busy = 1'b0;
    tick();
    check("mid after en", 32'(bus.tx_en), 1);
    check("mid after grant", 32'(bus.grant_id), 0);
    check("mid after ready", 32'(bus.req_ready), 32'b0001);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter between several byte sources, such as keyboard echo, score/status messages and debug output. Sits between the requesters and the transmit path of the `uart` wrapper. It runs on the system clock and hands one byte at a time to the transmitter through a level handshake that tolerates the slower baud domain. It waits for each frame to finish before granting the next requester.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `START_TIMEOUT`, default 20000: clk cycles to wait for `tx_busy` to rise after `tx_en` is asserted.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  N_REQ  requester i has a byte pending; held until `req_ready[i]`.
- `req_data`  in  8*N_REQ  byte of requester i at `[8*i+7:8*i]`; stable while `req_valid[i]` is high.
- `req_ready`  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- `tx_data`  out  8  byte presented to the transmitter; stable while `tx_en` or `tx_busy` is high.
- `tx_en`  out  1  start request to the transmitter, level, held until `tx_busy` is seen high.
- `tx_busy`  in  1  transmitter is framing a byte (already synchronised to `clk` by the caller).
- `grant_id`  out  $clog2(N_REQ)  index of the requester currently being served.
- `busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle pulse when a start was abandoned.

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- **IDLE:** if any `req_valid` bit is set, choose the requester g using round-robin search starting at pointer `ptr`.
  - At that edge: `tx_data <= req_data[g]`, `grant_id <= g`, `tx_en <= 1`, `req_ready[g] <= 1`, `ptr <= (g+1) mod N_REQ`, go to START.
  - With no `req_valid` bit set, stay in IDLE.
- **START:** `req_ready` returns to 0 after one cycle. The cycle counter increments each cycle.
  - If `tx_busy` = 1: `tx_en <= 0`, go to WAIT_DONE.
  - Else if the counter reaches `START_TIMEOUT`-1: `tx_en <= 0`, pulse `err_timeout`, go to IDLE. The byte is dropped (it was already acknowledged).
- **WAIT_DONE:** when `tx_busy` = 0, go to GAP.
- **GAP:** one cycle, then go to IDLE. This guarantees the transmitter has seen `tx_en` low before the next start.
- Round-robin rule: the requester just served gets the lowest priority next. `ptr` wraps from N_REQ-1 to 0.
- Every byte value 0x00..0xFF is passed unchanged; the arbiter does no filtering.
- `req_ready` is never asserted for a requester whose `req_valid` is low at the decision edge.
- At most one bit of `req_ready` is high in any cycle.
- Reset while in START or WAIT_DONE: everything returns to reset values at that edge and `tx_en` drops. The frame in flight is abandoned with no error pulse.

## Timing
- Reset values: `tx_en`=0, `tx_data`=0x00, `req_ready`=0, `grant_id`=0, `busy`=0, `err_timeout`=0, `ptr`=0, counter=0, state=IDLE.
- Decision latency: `req_valid` high in cycle t (while in IDLE) gives `tx_en`=1 and `req_ready`=1 in cycle t+1.
- `req_valid` is sampled on the same edge it is acted on. The requester drops `req_valid` (or presents its next byte) in the cycle after `req_ready`.
- `busy` is registered: it rises together with `tx_en` and falls in the cycle after GAP.
- Minimum spacing between two starts: frame time plus 3 clk cycles (the falling edge of `tx_busy`, GAP, and the IDLE decision).
- Simultaneous requests are all served in ptr order, one per frame. No requester waits more than N_REQ-1 frames.
- `tx_busy` already high on entry to START (from a stale frame) is treated as the acknowledgement.
- The counter is $clog2(START_TIMEOUT) bits wide and is cleared on entry to START.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 cycles with `req_valid`=4'b1111 → all outputs stay at their reset values and `req_ready` stays 0.
- **Single requester:** `req_valid[2]`=1 with data 0x41 → next cycle `tx_en`=1, `tx_data`=0x41, `grant_id`=2, `req_ready`=4'b0100 for 1 cycle. Model `tx_busy` high 5 cycles later for 100 cycles → `tx_en` falls 1 cycle after `tx_busy` rises and `busy` falls 2 cycles after `tx_busy` falls.
- **Round robin:** all four requesters continuously valid with data 0x10..0x13 → grant order 0,1,2,3,0; `tx_data` sequence 0x10,0x11,0x12,0x13,0x10; one `req_ready` bit per grant.
- **Pointer wrap and skip:** serve requester 3, then assert only `req_valid[1]` → grant 1; the next simultaneous request from 0 and 1 → grant 0 first.
- **Start timeout:** with `START_TIMEOUT`=8, keep `tx_busy`=0 → `tx_en` high exactly 8 cycles, `err_timeout` pulses once, state returns to IDLE and the next requester is granted.
- **Reset mid-frame:** assert `rst_n`=0 during WAIT_DONE → `tx_en`=0, `busy`=0, `ptr`=0 at the next edge; after release, requester 0 wins over requester 1.
